// File: rtl/stk_pkg.sv
// Shared types and sizing for the multi-context stack engine.
// Opcodes, error codes and the response record carried through S1 and the output stage.
package stk_pkg;

   localparam int W     = 128;
   localparam int N_CTX = 8;
   localparam int DEPTH = 16;
   localparam int IDW   = $clog2(N_CTX);
   localparam int IDXW  = $clog2(DEPTH);
   localparam int LVLW  = IDXW + 1;
   localparam int AW    = IDW + IDXW;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_PUSH = 3'd1,
      OP_POP  = 3'd2,
      OP_PEEK = 3'd3,
      OP_CLR  = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_OVFL = 2'd1,
      ERR_UNFL = 2'd2
   } err_t;

   typedef struct packed {
      logic [IDW-1:0]  id;
      logic [W-1:0]    dat;
      err_t            err;
      logic [LVLW-1:0] lvl;
   } rsp_t;

   // Each context owns a contiguous DEPTH-entry slice of the shared store.
   function automatic logic [AW-1:0] mem_addr(input logic [IDW-1:0] ctx, input logic [IDXW-1:0] idx);
      return {ctx, idx};
   endfunction

endpackage

// File: rtl/stk_mem.sv
// Shared stack store: N_CTX*DEPTH x W flop array, one write port and one combinational read port.
// Contents are deliberately left unreset.
module stk_mem
   import stk_pkg::*;
(
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdat,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdat
);

   logic [W-1:0] mem_q [N_CTX*DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdat;
      end
   end

   assign o_rdat = mem_q[i_raddr];

endmodule

// File: rtl/stk_mc.sv
// Multi-context LIFO engine: per-context occupancy counters, command decode with overflow/underflow
// detection, and a two-stage (S1, out) registered response path.
module stk_mc
   import stk_pkg::*;
(
   input  logic             clk,
   input  logic             arst,
   input  logic             i_cmd_vld,
   input  op_t              i_cmd_opcode,
   input  logic [IDW-1:0]   i_cmd_id,
   input  logic [W-1:0]     i_cmd_dat,
   output logic             o_rsp_vld,
   output logic [IDW-1:0]   o_rsp_id,
   output logic [W-1:0]     o_rsp_dat,
   output err_t             o_rsp_err,
   output logic [LVLW-1:0]  o_rsp_lvl,
   output logic [N_CTX-1:0] o_empty,
   output logic [N_CTX-1:0] o_full
);

   logic [LVLW-1:0]  cnt_q [N_CTX];
   logic [LVLW-1:0]  cnt_d [N_CTX];
   logic [LVLW-1:0]  cur_n;
   logic [IDXW-1:0]  rd_idx;
   logic [AW-1:0]    wr_addr;
   logic [AW-1:0]    rd_addr;
   logic             mem_we;
   logic [W-1:0]     rd_dat;
   logic             s1_vld_q, s1_vld_d;
   rsp_t             s1_q, s1_d;
   logic             out_vld_q;
   rsp_t             out_q;
   logic [N_CTX-1:0] empty_q, empty_d;
   logic [N_CTX-1:0] full_q, full_d;

   assign cur_n   = cnt_q[i_cmd_id];
   assign rd_idx  = cur_n[IDXW-1:0] - IDXW'(1);
   assign wr_addr = mem_addr(i_cmd_id, cur_n[IDXW-1:0]);
   assign rd_addr = mem_addr(i_cmd_id, rd_idx);

   stk_mem u_mem (
      .clk     (clk),
      .i_we    (mem_we),
      .i_waddr (wr_addr),
      .i_wdat  (i_cmd_dat),
      .i_raddr (rd_addr),
      .o_rdat  (rd_dat)
   );

   always_comb begin
      cnt_d    = cnt_q;
      mem_we   = 1'b0;
      s1_vld_d = 1'b0;
      s1_d.id  = i_cmd_id;
      s1_d.dat = '0;
      s1_d.err = ERR_NONE;
      s1_d.lvl = cur_n;
      if (i_cmd_vld) begin
         case (i_cmd_opcode)
            OP_PUSH: begin
               s1_vld_d = 1'b1;
               if (cur_n == LVLW'(DEPTH)) begin
                  s1_d.err = ERR_OVFL;
               end else begin
                  mem_we          = 1'b1;
                  cnt_d[i_cmd_id] = cur_n + LVLW'(1);
                  s1_d.lvl        = cur_n + LVLW'(1);
               end
            end
            OP_POP, OP_PEEK: begin
               s1_vld_d = 1'b1;
               if (cur_n == '0) begin
                  s1_d.err = ERR_UNFL;
               end else begin
                  s1_d.dat = rd_dat;
                  if (i_cmd_opcode == OP_POP) begin
                     cnt_d[i_cmd_id] = cur_n - LVLW'(1);
                     s1_d.lvl        = cur_n - LVLW'(1);
                  end
               end
            end
            OP_CLR: begin
               s1_vld_d        = 1'b1;
               cnt_d[i_cmd_id] = '0;
               s1_d.lvl        = '0;
            end
            default: ;
         endcase
      end
      // Idle slots carry an all-zero record so the outputs read 0 between responses.
      if (!s1_vld_d) begin
         s1_d = '0;
      end
   end

   for (genvar gi = 0; gi < N_CTX; gi++) begin : g_flags
      assign empty_d[gi] = (cnt_q[gi] == '0);
      assign full_d[gi]  = (cnt_q[gi] == LVLW'(DEPTH));
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < N_CTX; i++) begin
            cnt_q[i] <= '0;
         end
         s1_vld_q  <= 1'b0;
         s1_q      <= '0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
         empty_q   <= '1;
         full_q    <= '0;
      end else begin
         cnt_q     <= cnt_d;
         s1_vld_q  <= s1_vld_d;
         s1_q      <= s1_d;
         out_vld_q <= s1_vld_q;
         out_q     <= s1_q;
         empty_q   <= empty_d;
         full_q    <= full_d;
      end
   end

   assign o_rsp_vld = out_vld_q;
   assign o_rsp_id  = out_q.id;
   assign o_rsp_dat = out_q.dat;
   assign o_rsp_err = out_q.err;
   assign o_rsp_lvl = out_q.lvl;
   assign o_empty   = empty_q;
   assign o_full    = full_q;

   a_id_range: assert property (@(posedge clk) disable iff (arst)
      i_cmd_vld |-> (int'(i_cmd_id) < N_CTX));

endmodule
